// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: owns the command/address/data pins and hands them to the
// init, auto-refresh, write or read engine with fixed priority aref > write > read.
module sdram_arbit #(
  parameter logic [3:0] CMD_NOP = 4'b0111
) (
  input  logic        clk_100m,
  input  logic        rstn,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_bank,
  input  logic [12:0] init_addr,
  input  logic        init_end,
  input  logic        aref_req,
  input  logic        aref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [1:0]  aref_bank,
  input  logic [12:0] aref_addr,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_bank,
  input  logic [12:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic        wr_sdram_en,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_bank,
  input  logic [12:0] rd_addr,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addr,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        aref_en_r;
  logic        wr_en_r;
  logic        rd_en_r;
  logic [3:0]  cmd_s;
  logic [1:0]  ba_s;
  logic [12:0] addr_s;
  logic [15:0] dq_out_s;
  logic        dq_oe_s;

  // State register.
  always_ff @(posedge clk_100m or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: fixed-priority grant from ARBIT; an owner only leaves on its own end pulse.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (init_end) state_nxt_s = ARBIT;
        else          state_nxt_s = IDLE;
      end
      ARBIT: begin
        if (aref_req)     state_nxt_s = AREF;
        else if (wr_req)  state_nxt_s = WRITE;
        else if (rd_req)  state_nxt_s = READ;
        else              state_nxt_s = ARBIT;
      end
      AREF: begin
        if (aref_end) state_nxt_s = ARBIT;
        else          state_nxt_s = AREF;
      end
      WRITE: begin
        if (wr_end) state_nxt_s = ARBIT;
        else        state_nxt_s = WRITE;
      end
      READ: begin
        if (rd_end) state_nxt_s = ARBIT;
        else        state_nxt_s = READ;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Grants are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk_100m or negedge rstn) begin
    if (!rstn) begin
      aref_en_r <= 1'b0;
      wr_en_r   <= 1'b0;
      rd_en_r   <= 1'b0;
    end else begin
      aref_en_r <= (state_nxt_s == AREF);
      wr_en_r   <= (state_nxt_s == WRITE);
      rd_en_r   <= (state_nxt_s == READ);
    end
  end

  // Command/bank/address pin mux selected by the current owner.
  always_comb begin
    cmd_s  = CMD_NOP;
    ba_s   = 2'b00;
    addr_s = 13'h0000;
    case (state_r)
      IDLE: begin
        cmd_s  = init_cmd;
        ba_s   = init_bank;
        addr_s = init_addr;
      end
      AREF: begin
        cmd_s  = aref_cmd;
        ba_s   = aref_bank;
        addr_s = aref_addr;
      end
      WRITE: begin
        cmd_s  = wr_cmd;
        ba_s   = wr_bank;
        addr_s = wr_addr;
      end
      READ: begin
        cmd_s  = rd_cmd;
        ba_s   = rd_bank;
        addr_s = rd_addr;
      end
      ARBIT: begin
        cmd_s  = CMD_NOP;
        ba_s   = 2'b00;
        addr_s = 13'h0000;
      end
      default: begin
        cmd_s  = CMD_NOP;
        ba_s   = 2'b00;
        addr_s = 13'h0000;
      end
    endcase
  end

  // Only the write engine may drive DQ.
  always_comb begin
    dq_oe_s  = 1'b0;
    dq_out_s = 16'h0000;
    if (state_r == WRITE) begin
      dq_oe_s  = wr_sdram_en;
      dq_out_s = wr_data;
    end else begin
      dq_oe_s  = 1'b0;
      dq_out_s = 16'h0000;
    end
  end

  assign aref_en      = aref_en_r;
  assign wr_en        = wr_en_r;
  assign rd_en        = rd_en_r;
  assign sdram_cke    = 1'b1;
  assign sdram_cs_n   = cmd_s[3];
  assign sdram_ras_n  = cmd_s[2];
  assign sdram_cas_n  = cmd_s[1];
  assign sdram_we_n   = cmd_s[0];
  assign sdram_ba     = ba_s;
  assign sdram_addr   = addr_s;
  assign sdram_dq_out = dq_out_s;
  assign sdram_dq_oe  = dq_oe_s;

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed scenarios plus random traffic checked every
// cycle against an owner-tracking model of the arbitration rules.
module tb_sdram_arbit;

  logic        clk_100m = 1'b0;
  logic        rstn;
  logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [1:0]  init_bank, aref_bank, wr_bank, rd_bank;
  logic [12:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic        init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
  logic [15:0] wr_data;
  logic        wr_sdram_en;
  logic        aref_en, wr_en, rd_en;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;

  int total = 0;
  int bad   = 0;

  // Who owns the bus: before init, nobody (arbitrating), or one of the engines.
  localparam int O_PRE  = 0;
  localparam int O_NONE = 1;
  localparam int O_AREF = 2;
  localparam int O_WR   = 3;
  localparam int O_RD   = 4;
  int owner = O_PRE;

  sdram_arbit #(.CMD_NOP(4'b0111)) dut (
    .clk_100m(clk_100m), .rstn(rstn),
    .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr), .init_end(init_end),
    .aref_req(aref_req), .aref_end(aref_end),
    .aref_cmd(aref_cmd), .aref_bank(aref_bank), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end),
    .wr_cmd(wr_cmd), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_sdram_en(wr_sdram_en),
    .rd_req(rd_req), .rd_end(rd_end),
    .rd_cmd(rd_cmd), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
  );

  always #5 clk_100m = ~clk_100m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Owner changes at a clock edge according to the arbitration rules.
  task automatic model_update();
    if (!rstn) owner = O_PRE;
    else if (owner == O_PRE) begin
      if (init_end) owner = O_NONE;
    end else if (owner == O_NONE) begin
      if (aref_req)      owner = O_AREF;
      else if (wr_req)   owner = O_WR;
      else if (rd_req)   owner = O_RD;
    end else if (owner == O_AREF && aref_end) owner = O_NONE;
    else if (owner == O_WR && wr_end)         owner = O_NONE;
    else if (owner == O_RD && rd_end)         owner = O_NONE;
  endtask

  task automatic compare();
    logic [2:0]  g_exp, g_act;
    logic [36:0] b_exp, b_act;
    logic [3:0]  c;
    logic [1:0]  b;
    logic [12:0] a;
    logic        oe;
    logic [15:0] d;
    g_exp = {owner == O_AREF, owner == O_WR, owner == O_RD};
    g_act = {aref_en, wr_en, rd_en};
    c = 4'b0111; b = 2'b00; a = 13'h0000; oe = 1'b0; d = 16'h0000;
    if (owner == O_PRE)  begin c = init_cmd; b = init_bank; a = init_addr; end
    if (owner == O_AREF) begin c = aref_cmd; b = aref_bank; a = aref_addr; end
    if (owner == O_WR)   begin c = wr_cmd;   b = wr_bank;   a = wr_addr; oe = wr_sdram_en; d = wr_data; end
    if (owner == O_RD)   begin c = rd_cmd;   b = rd_bank;   a = rd_addr; end
    b_exp = {1'b1, c, b, a, oe, d};
    b_act = {sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
             sdram_ba, sdram_addr, sdram_dq_oe, sdram_dq_out};
    chk("grants", 64'(g_act), 64'(g_exp));
    chk("bus", 64'(b_act), 64'(b_exp));
    chk("onehot_grant", 64'($countones(g_act) <= 1), 64'd1);
  endtask

  task automatic step();
    @(posedge clk_100m);
    model_update();
    #1 compare();
    @(negedge clk_100m);
  endtask

  task automatic rand_bus();
    init_cmd = 4'($urandom); init_bank = 2'($urandom); init_addr = 13'($urandom);
    aref_cmd = 4'($urandom); aref_bank = 2'($urandom); aref_addr = 13'($urandom);
    wr_cmd   = 4'($urandom); wr_bank   = 2'($urandom); wr_addr   = 13'($urandom);
    rd_cmd   = 4'($urandom); rd_bank   = 2'($urandom); rd_addr   = 13'($urandom);
    wr_data  = 16'($urandom); wr_sdram_en = 1'($urandom);
  endtask

  initial begin
    rstn = 1'b0;
    init_end = 1'b0; aref_req = 1'b0; aref_end = 1'b0;
    wr_req = 1'b0; wr_end = 1'b0; rd_req = 1'b0; rd_end = 1'b0;
    rand_bus();
    init_cmd = 4'b0010;
    wr_sdram_en = 1'b1;
    @(negedge clk_100m);
    #1 chk("reset_grants", 64'({aref_en, wr_en, rd_en}), 64'd0);
    chk("reset_dq_oe", 64'(sdram_dq_oe), 64'd0);
    step(); step();

    // Held in IDLE while init runs, even with a refresh request pending.
    rstn = 1'b1; aref_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_grants", 64'({aref_en, wr_en, rd_en}), 64'd0);
      chk("idle_cmd", 64'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 64'(4'b0010));
    end

    // Priority chain aref > wr > rd with one ARBIT cycle between grants.
    init_end = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    step();
    chk("arbit_cmd", 64'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 64'(4'b0111));
    chk("arbit_addr", 64'({sdram_ba, sdram_addr}), 64'd0);
    step();
    chk("prio_aref", 64'({aref_en, wr_en, rd_en}), 64'(3'b100));
    aref_end = 1'b1; step(); aref_end = 1'b0; aref_req = 1'b0;
    chk("aref_to_arbit", 64'({aref_en, wr_en, rd_en}), 64'd0);
    chk("arbit_nop", 64'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 64'(4'b0111));
    step();
    chk("prio_wr", 64'({aref_en, wr_en, rd_en}), 64'(3'b010));
    wr_end = 1'b1; step(); wr_end = 1'b0; wr_req = 1'b0;
    step();
    chk("prio_rd", 64'({aref_en, wr_en, rd_en}), 64'(3'b001));

    // Foreign end pulse ignored while refreshing.
    rd_end = 1'b1; step(); rd_end = 1'b0; rd_req = 1'b0; aref_req = 1'b1;
    step(); aref_req = 1'b0; rd_end = 1'b1;
    step(); rd_end = 1'b0;
    chk("ignore_rd_end", 64'({aref_en, wr_en, rd_en}), 64'(3'b100));
    aref_end = 1'b1; step(); aref_end = 1'b0;

    // No preemption of a write; DQ driven only in WRITE.
    wr_req = 1'b1; step(); wr_req = 1'b0;
    wr_data = 16'hA5A5; wr_sdram_en = 1'b1; aref_req = 1'b1;
    step();
    chk("no_preempt", 64'({aref_en, wr_en, rd_en}), 64'(3'b010));
    chk("dq_oe_wr", 64'(sdram_dq_oe), 64'd1);
    chk("dq_out_wr", 64'(sdram_dq_out), 64'(16'hA5A5));
    wr_end = 1'b1; step(); wr_end = 1'b0;
    step();
    chk("aref_after_wr", 64'({aref_en, wr_en, rd_en}), 64'(3'b100));
    aref_req = 1'b0; aref_end = 1'b1; step(); aref_end = 1'b0; rd_req = 1'b1;
    step();
    chk("dq_oe_rd", 64'(sdram_dq_oe), 64'd0);
    chk("rd_granted", 64'(rd_en), 64'd1);

    // Asynchronous reset in mid-read.
    #2 rstn = 1'b0; owner = O_PRE;
    #1 chk("async_drop", 64'({aref_en, wr_en, rd_en}), 64'd0);
    @(negedge clk_100m);
    step();
    rstn = 1'b1; init_end = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_idle", 64'(rd_en), 64'd0);
    end
    init_end = 1'b1; step(); step();
    chk("regrant_rd", 64'(rd_en), 64'd1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rand_bus();
      aref_req = ($urandom_range(0, 3) == 0);
      wr_req   = ($urandom_range(0, 1) == 0);
      rd_req   = ($urandom_range(0, 1) == 0);
      aref_end = ($urandom_range(0, 3) == 0);
      wr_end   = ($urandom_range(0, 3) == 0);
      rd_end   = ($urandom_range(0, 3) == 0);
      init_end = ($urandom_range(0, 7) != 0);
      rstn     = ($urandom_range(0, 99) != 0);
      if (!rstn) owner = O_PRE;
      #1 compare();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 SHALL have parameter CMD_NOP, default 4'b0111, meaning the {cs_n,ras_n,cas_n,we_n} code driven when no requester owns the bus.
REQ-002 SHALL have port clk_100m  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports init_cmd/init_bank/init_addr  input  4/2/13  command, bank and address from the init sequencer.
REQ-005 SHALL have port init_end  input  1  init sequence complete; held high thereafter.
REQ-006 SHALL have ports aref_req, aref_end  input  1 each  auto-refresh request; refresh burst done (1-cycle pulse).
REQ-007 SHALL have ports aref_cmd/aref_bank/aref_addr  input  4/2/13  refresh-module bus.
REQ-008 SHALL have ports wr_req, wr_end  input  1 each  write request; write burst done (1-cycle pulse).
REQ-009 SHALL have ports wr_cmd/wr_bank/wr_addr  input  4/2/13; wr_data  input  16; wr_sdram_en  input  1  write-data drive enable.
REQ-010 SHALL have ports rd_req, rd_end  input  1 each; rd_cmd/rd_bank/rd_addr  input  4/2/13.
REQ-011 SHALL have ports aref_en, wr_en, rd_en  output  1 each  grant to the respective module, registered.
REQ-012 SHALL have ports sdram_cke  output  1; sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  output  1 each; sdram_ba  output  2; sdram_addr  output  13.
REQ-013 SHALL have ports sdram_dq_out  output  16  write data; sdram_dq_oe  output  1  tri-state enable for the pad-level DQ buffer.

Function
REQ-014 SHALL implement a registered FSM with states IDLE, ARBIT, AREF, WRITE, READ.
REQ-015 IDLE SHALL transition to ARBIT on the first rising edge where init_end=1; otherwise remain in IDLE.
REQ-016 ARBIT SHALL grant with fixed priority aref_req > wr_req > rd_req, moving to AREF, WRITE or READ respectively on the same edge.
REQ-017 ARBIT with no request SHALL remain in ARBIT.
REQ-018 aref_en SHALL be 1 exactly while state=AREF; wr_en exactly while state=WRITE; rd_en exactly while state=READ; at most one grant is high in any cycle.
REQ-019 AREF/WRITE/READ SHALL return to ARBIT on the edge where the matching *_end=1; end pulses from non-owners are ignored.
REQ-020 Requests arriving during an active grant SHALL NOT preempt it; they are evaluated on the first ARBIT cycle after return.
REQ-021 Grant latency SHALL be one clock: request sampled high in ARBIT at edge N gives *_en=1 from edge N.
REQ-022 {sdram_cs_n,ras_n,cas_n,we_n}, sdram_ba, sdram_addr SHALL be combinationally muxed by state: IDLE->init_*, AREF->aref_*, WRITE->wr_*, READ->rd_*, ARBIT->CMD_NOP with ba=2'b00, addr=13'h0000.
REQ-023 sdram_dq_oe SHALL equal wr_sdram_en when state=WRITE, else 0; sdram_dq_out SHALL equal wr_data when state=WRITE, else 16'h0000.
REQ-024 sdram_cke SHALL be constant 1.
REQ-025 If init_end falls while not in IDLE, behaviour is unchanged (init_end only gates the IDLE exit).

Reset
REQ-026 rstn=0 SHALL force state=IDLE and aref_en=wr_en=rd_en=0 asynchronously; command outputs then follow init_* per REQ-022, dq_oe=0, dq_out=0, cke=1.
REQ-027 Reset asserted mid-burst SHALL drop the active grant immediately with no end pulse required; after release the FSM restarts from IDLE.

Verification
REQ-028 init_end=0 for 20 cycles with aref_req=1 -> state IDLE, all grants 0, sdram cmd equals init_cmd each cycle.
REQ-029 init_end=1, aref_req=wr_req=rd_req=1 in ARBIT -> aref_en=1 next edge; after aref_end pulse -> ARBIT one cycle (cmd=4'b0111) then wr_en=1; after wr_end -> rd_en=1.
REQ-030 WRITE granted, aref_req rises mid-burst -> wr_en stays 1 until wr_end; aref_en=1 one ARBIT cycle later; no cycle with two grants high.
REQ-031 WRITE with wr_sdram_en=1, wr_data=16'hA5A5 -> sdram_dq_oe=1, sdram_dq_out=16'hA5A5; in READ with wr_sdram_en=1 -> dq_oe=0.
REQ-032 rd_end pulse while state=AREF -> ignored, aref_en stays 1 until aref_end.
REQ-033 rstn pulsed low during READ -> rd_en=0 within the same cycle, state IDLE, re-grant only after init_end=1 and a new request.
